// File: rtl/sa_pkg.sv
// Shared definitions for the systolic PE family: width defaults, accumulator sizing
// helper and the own-result buffer state encoding.
package sa_pkg;

    localparam int SA_DATA_WIDTH_DEF = 8;
    localparam int SA_ACC_GUARD      = 4;
    localparam int SA_ACC_WIDTH_DEF  = 2 * SA_DATA_WIDTH_DEF + SA_ACC_GUARD;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        PEND = 1'b1
    } pe_state_t;

    // Smallest accumulator that sums k full-width products without wrapping.
    function automatic int acc_width_min(input int dw, input int k);
        return 2 * dw + ((k > 1) ? $clog2(k) : 0);
    endfunction

endpackage

// File: rtl/sa_pe_mac.sv
// Multiply-accumulate core: full-width product, sign/zero extension, add and acc register.
// Define SA_PE_SAT_EN to saturate the sum at the ACC_WIDTH bounds instead of wrapping.
module sa_pe_mac import sa_pkg::*; #(
    parameter int DATA_WIDTH = SA_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + SA_ACC_GUARD,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  fire,
    input  logic                  last,
    output logic [ACC_WIDTH-1:0]  sum
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam bit SX = (SIGNED != 0);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;

    // Extending to the product width first keeps the low PW bits exact for both signednesses.
    assign a_ext = {{DATA_WIDTH{SX & a[DATA_WIDTH-1]}}, a};
    assign b_ext = {{DATA_WIDTH{SX & b[DATA_WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    generate
        if (ACC_WIDTH > PW) begin : g_ext
            assign prod_ext = {{(ACC_WIDTH - PW){SX & prod[PW-1]}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

`ifdef SA_PE_SAT_EN
    logic [ACC_WIDTH:0] sum_wide;

    assign sum_wide = {SX & acc_reg[ACC_WIDTH-1], acc_reg}
                    + {SX & prod_ext[ACC_WIDTH-1], prod_ext};

    always_comb begin
        sum = sum_wide[ACC_WIDTH-1:0];
        if (SX) begin
            if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
                sum = {sum_wide[ACC_WIDTH], {(ACC_WIDTH-1){~sum_wide[ACC_WIDTH]}}};
            end
        end else if (sum_wide[ACC_WIDTH]) begin
            sum = '1;
        end
    end
`else
    assign sum = acc_reg + prod_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (fire) begin
            acc_reg <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/sa_pe_os.sv
// Output-stationary systolic PE: operand pass-through, tile accumulation, double-buffered
// result hold and a backpressured drain register. SA_PE_SAT_EN selects saturating accumulation.
module sa_pe_os import sa_pkg::*; #(
    parameter int DATA_WIDTH = SA_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + SA_ACC_GUARD,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_valid_in,
    input  logic                  a_last_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  b_valid_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_valid_out,
    output logic                  a_last_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_valid_out,
    input  logic [ACC_WIDTH-1:0]  c_in,
    input  logic                  c_valid_in,
    output logic                  c_ready_out,
    output logic [ACC_WIDTH-1:0]  c_out,
    output logic                  c_valid_out,
    input  logic                  c_ready_in,
    output logic                  err
);

    logic                 fire;
    logic                 mismatch;
    logic                 last_mac;
    logic                 hold_v;
    logic                 r_free;
    logic                 hold_xfer;
    logic                 hold_load;
    logic                 overflow;
    logic                 c_take;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] hold_reg;
    logic [ACC_WIDTH-1:0] r_reg;
    logic                 r_v_reg;
    logic                 err_reg;
    pe_state_t            state_reg;
    pe_state_t            state_next;

    assign fire     = a_valid_in & b_valid_in;
    assign mismatch = a_valid_in ^ b_valid_in;
    assign last_mac = fire & a_last_in;

    sa_pe_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .a    (a_in),
        .b    (b_in),
        .fire (fire),
        .last (a_last_in),
        .sum  (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            a_last_out  <= 1'b0;
            b_out       <= '0;
            b_valid_out <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            a_last_out  <= a_last_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
        end
    end

    // Own result always wins R; upstream results wait until hold has moved down.
    assign hold_v      = (state_reg == PEND);
    assign r_free      = ~r_v_reg | c_ready_in;
    assign hold_xfer   = hold_v & r_free;
    assign c_ready_out = r_free & ~hold_v;
    assign c_take      = c_valid_in & c_ready_out;
    assign hold_load   = last_mac & (~hold_v | hold_xfer);
    assign overflow    = last_mac & hold_v & ~hold_xfer;

    always_comb begin
        state_next = state_reg;
        if (hold_load) begin
            state_next = PEND;
        end else if (hold_xfer) begin
            state_next = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACC;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (hold_load) begin
                hold_reg <= sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg   <= '0;
            r_v_reg <= 1'b0;
        end else if (hold_xfer) begin
            r_reg   <= hold_reg;
            r_v_reg <= 1'b1;
        end else if (c_take) begin
            r_reg   <= c_in;
            r_v_reg <= 1'b1;
        end else if (r_v_reg & c_ready_in) begin
            r_v_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (mismatch | overflow) begin
            err_reg <= 1'b1;
        end
    end

    assign c_out       = r_reg;
    assign c_valid_out = r_v_reg;
    assign err         = err_reg;

endmodule

// File: doc/sa_pe_os.md
# sa_pe_os

Output-stationary systolic processing element with valid-qualified operands, tile framing and a backpressured result drain chain. Tiles into an R×C array: operands flow left→right (a) and top→bottom (b), and each PE accumulates one output element. Finished results shift down the column to the array's bottom edge. Double buffering lets the next tile start accumulating while the previous result drains.

## Interface
- DATA_WIDTH, 8, operand width
- ACC_WIDTH, 2*DATA_WIDTH+4, accumulator/result width; must be ≥ 2*DATA_WIDTH
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- a_in, a_valid_in, a_last_in  in  DATA_WIDTH, 1, 1  operand from left; last marks the final operand of a tile
- b_in, b_valid_in  in  DATA_WIDTH, 1  operand from top
- a_out, a_valid_out, a_last_out  out  DATA_WIDTH, 1, 1  registered copy to the right
- b_out, b_valid_out  out  DATA_WIDTH, 1  registered copy to the bottom
- c_in, c_valid_in  in  ACC_WIDTH, 1  result from the PE above (tie 0 at the top row)
- c_ready_out  out  1  to the PE above; this PE can accept c_in
- c_out, c_valid_out  out  ACC_WIDTH, 1  result toward the bottom
- c_ready_in  in  1  from the PE below or the array sink
- err  out  1  sticky error: operand mismatch or result overflow

## Operation
- MAC fires when a_valid_in & b_valid_in.
  - Product: full 2*DATA_WIDTH, sign- or zero-extended per SIGNED to ACC_WIDTH.
  - Accumulator update: acc <= acc + prod, wrapping modulo 2^ACC_WIDTH.
- a_last_in is only meaningful when the MAC fires.
  - On a last MAC, acc + prod is written into the hold register, hold_v is set, and acc is cleared to 0.
  - The next tile's first MAC starts from 0 on the following cycle.
- If exactly one of a_valid_in or b_valid_in is high:
  - No MAC takes place.
  - Pass-through still occurs.
  - err is set.
- Drain chain uses register R, with c_out = R and c_valid_out = R_v.
  - R is vacated when R_v & c_ready_in.
  - R loads when it is empty or being vacated this cycle.
  - Load priority: hold (own result) first, then c_in.
- c_ready_out = (!R_v | c_ready_in) & !hold_v.
  - Upstream results stall while the own result is pending.
  - Column output order is therefore bottom PE first, then upward.
- FSM over the own-result buffer:
  - ACC: hold_v=0.
  - PEND: hold_v=1, waiting for R.
  - ACC→PEND on a last MAC.
  - PEND→ACC when hold is transferred into R.
- Overflow: a last MAC while in PEND sets err. The new result is dropped, hold keeps the older value, and acc still clears.
- err clears only on rst.

## Timing
- a_out, b_out, their valids and a_last_out: exactly 1 cycle latency, unconditional (no backpressure on operands).
- Last MAC sampled at edge t:
  - hold_v=1 after t.
  - Earliest R load / c_valid_out=1 after edge t+1, i.e. result latency 2.
- c_in to c_out through a free R: 1 cycle per PE.
- Simultaneous hold→R and last MAC in the same cycle is legal: the FSM stays in PEND with the new value.
- Simultaneous R vacate and reload: no bubble; throughput 1 result/cycle.
- Reset values (every output): a_out, b_out, c_out = 0; all valids, a_last_out, err = 0; c_ready_out = 1 (driven from zeroed state).
- Internal reset values: acc, hold, R = 0; hold_v, R_v = 0; FSM = ACC.
- rst mid-tile or mid-drain discards all partial and pending results, with no output glitch beyond the reset values.

## Configuration
- SA_PE_SAT_EN defined: the accumulator and the last-MAC sum saturate at the ACC_WIDTH bounds (signed or unsigned per SIGNED) instead of wrapping. Saturation does not set err.
- SA_PE_SAT_EN undefined: modulo wrap. No saturation logic is instantiated.

## Structure
- Shared package sa_pkg holds:
  - the ACC_WIDTH default constant;
  - the function computing the minimum ACC_WIDTH for a given K;
  - the FSM state enum {ACC, PEND}.
- Sub-module sa_pe_mac: product, extension, add, and optional saturation. It is combinational plus the acc register and is reusable by weight-stationary variants.
- Drain chain and FSM stay in sa_pe_os.

## Test plan
- SIGNED=1, DW=8: stream a=3,-2,5 and b=4,7,-1 with last on the 3rd → c_out=-7 (12-14-5) with c_valid_out 2 cycles after the last; a_out/b_out echo the inputs 1 cycle late.
- Two back-to-back tiles with c_ready_in=1 → results -7 then the second tile's sum, contiguous; the second accumulation starts from 0.
- Hold c_ready_in=0, complete tile 1 → R full; complete tile 2 → PEND; complete tile 3 → err=1, tile-3 result lost; release → tile 1 then tile 2 emerge in order.
- Chain: c_valid_in=1 with c_in=0x55 while own hold is pending → c_ready_out=0 until the own result loads into R; output order is own result, then 0x55.
- a_valid_in=1, b_valid_in=0 → acc unchanged, err=1, a_out valid next cycle.
- SA_PE_SAT_EN, ACC_WIDTH=16, SIGNED: 3 × (127·127) accumulation → 32767 (undefined build: wraps to -17149, i.e. 48387−65536); assert rst mid-tile → all outputs return to reset values next cycle.
